encoded_frame_tx: RTL and testbench



---
 rtl/encoded_frame_tx.sv | 145 ++++++++++++++
 tb/tb_encoded_frame_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoded_frame_tx.sv
// Frames a parallel payload as SOF 0xA5, length, payload (byte 0 first), XOR checksum,
// handing each byte to async_transmitter with a start/busy handshake and an inter-byte gap.
module encoded_frame_tx #(
    parameter int FRAME_BYTES = 12,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_valid,
    input  logic [8*FRAME_BYTES-1:0] frame_data,
    output logic                     frame_ready,
    input  logic                     abort,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic                     done,
    output logic                     fault,
    output logic [2:0]               state_dbg
);
    // Handshake: frame_valid/frame_ready transfer a frame on a clock where both are high;
    // toward the transmitter, tx_start is a one-cycle request acknowledged by tx_busy rising,
    // and the byte is complete when tx_busy falls again.
    localparam int                 GAP_W    = $clog2(GAP_CYCLES) + 1;
    localparam int                 ACK_W    = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [8:0]         LAST_IDX = 9'(FRAME_BYTES + 2);
    localparam logic [7:0]         LEN_BYTE = 8'(FRAME_BYTES);
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_CYCLES);
    localparam logic [ACK_W-1:0]   ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t                   state;
    logic [8*FRAME_BYTES-1:0] payload;
    logic [7:0]               chk;
    logic [8:0]               idx;
    logic [GAP_W-1:0]         gap_cnt;
    logic [ACK_W-1:0]         ack_cnt;

    function automatic logic [7:0] byte_at(input logic [8:0] i);
        logic [7:0] b;
        b = 8'h00;
        if (i == 9'd0) begin
            b = 8'hA5;
        end else if (i == 9'd1) begin
            b = LEN_BYTE;
        end else if (i == LAST_IDX) begin
            b = chk;
        end else begin
            for (int k = 0; k < FRAME_BYTES; k++) begin
                if (i == 9'(k + 2)) b = payload[8*k +: 8];
            end
        end
        return b;
    endfunction

    // Ready drops while a byte orphaned by abort is still on the line.
    assign frame_ready = (state == S_IDLE) && !tx_busy;
    assign state_dbg   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            payload  <= '0;
            chk      <= '0;
            idx      <= '0;
            gap_cnt  <= '0;
            ack_cnt  <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (frame_valid && frame_ready) begin
                            payload  <= frame_data;
                            chk      <= '0;
                            idx      <= '0;
                            fault    <= 1'b0;
                            tx_data  <= 8'hA5;
                            tx_start <= 1'b1;
                            state    <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        // SOF and the checksum itself stay out of the checksum.
                        if (idx != 9'd0 && idx != LAST_IDX) chk <= chk ^ tx_data;
                        ack_cnt <= ACK_W'(1);
                        state   <= S_WAIT_ACK;
                    end
                    S_WAIT_ACK: begin
                        if (tx_busy) begin
                            state <= S_WAIT_DONE;
                        end else if (ack_cnt >= ACK_LAST) begin
                            fault <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            ack_cnt <= ack_cnt + 1'b1;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (!tx_busy) begin
                            if (idx == LAST_IDX) begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                idx <= idx + 9'd1;
                                if (GAP_CYCLES > 0) begin
                                    gap_cnt <= GAP_W'(1);
                                    state   <= S_GAP;
                                end else begin
                                    tx_data  <= byte_at(idx + 9'd1);
                                    tx_start <= 1'b1;
                                    state    <= S_ISSUE;
                                end
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt >= GAP_LAST) begin
                            tx_data  <= byte_at(idx);
                            tx_start <= 1'b1;
                            state    <= S_ISSUE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_encoded_frame_tx.sv
// Bench for encoded_frame_tx: two instances (4-byte frames with gap 2, 12-byte frames with
// no gap) driven by a behavioural transmitter and checked against a byte-stream model.
module tb_encoded_frame_tx;
    localparam int N0 = 4;
    localparam int N1 = 12;
    localparam int G0 = 2;
    localparam int G1 = 0;
    localparam int ACK = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        frame_valid[2];
    logic [31:0] fdata0;
    logic [95:0] fdata1;
    logic        frame_ready[2];
    logic        abort[2];
    logic        tx_busy[2];
    logic        tx_start[2];
    logic [7:0]  tx_data[2];
    logic        done[2];
    logic        fault[2];
    logic [2:0]  state_dbg[2];

    encoded_frame_tx #(.FRAME_BYTES(N0), .GAP_CYCLES(G0), .ACK_TIMEOUT(ACK)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid[0]), .frame_data(fdata0),
        .frame_ready(frame_ready[0]), .abort(abort[0]), .tx_busy(tx_busy[0]),
        .tx_start(tx_start[0]), .tx_data(tx_data[0]), .done(done[0]), .fault(fault[0]),
        .state_dbg(state_dbg[0])
    );

    encoded_frame_tx #(.FRAME_BYTES(N1), .GAP_CYCLES(G1), .ACK_TIMEOUT(ACK)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid[1]), .frame_data(fdata1),
        .frame_ready(frame_ready[1]), .abort(abort[1]), .tx_busy(tx_busy[1]),
        .tx_start(tx_start[1]), .tx_data(tx_data[1]), .done(done[1]), .fault(fault[1]),
        .state_dbg(state_dbg[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event within bound, want event", name);
    endtask

    // ---------------- transmitter model ----------------
    int busy_len = 4;
    bit never_ack[2];
    int bcnt[2];

    always @(posedge clk or negedge rst_n) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                tx_busy[u] <= 1'b0;
                bcnt[u]    <= 0;
            end else if (tx_busy[u]) begin
                if (bcnt[u] == 0) tx_busy[u] <= 1'b0;
                else bcnt[u] <= bcnt[u] - 1;
            end else if (tx_start[u] && !never_ack[u]) begin
                tx_busy[u] <= 1'b1;
                bcnt[u]    <= busy_len - 1;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int  cur = 0;
    int  cyc = 0;
    int  acc_cyc = 0;
    int  fall_cyc = 0;
    bit  acc_pend = 0;
    bit  fall_pend = 0;
    bit  prev_busy = 0;
    bit  prev_start = 0;
    logic [7:0] held = 8'h00;
    int  done_cnt = 0;

    function automatic int gap_of(input int u);
        return (u == 0) ? G0 : G1;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            acc_pend   = 0;
            fall_pend  = 0;
            prev_busy  = 0;
            prev_start = 0;
        end else begin
            if (tx_start[cur]) begin
                got_q.push_back(tx_data[cur]);
                held = tx_data[cur];
                check("start_single_cycle", 64'(prev_start), 64'd0);
                check("start_line_idle", 64'(tx_busy[cur]), 64'd0);
                if (acc_pend) check("first_start_latency", 64'(cyc - acc_cyc), 64'd1);
                if (fall_pend) check("gap_latency", 64'(cyc - fall_cyc), 64'(1 + gap_of(cur)));
                acc_pend  = 0;
                fall_pend = 0;
            end
            if (done[cur]) begin
                done_cnt++;
                check("done_latency", fall_pend ? 64'(cyc - fall_cyc) : 64'd999, 64'd1);
                check("done_ready", 64'(frame_ready[cur]), 64'd1);
                fall_pend = 0;
            end
            if (prev_busy && !tx_busy[cur]) begin
                check("tx_data_stable", 64'(tx_data[cur]), 64'(held));
                fall_pend = 1;
                fall_cyc  = cyc;
            end
            if (abort[cur]) fall_pend = 0;
            if (frame_valid[cur] && frame_ready[cur]) begin
                acc_pend  = 1;
                acc_cyc   = cyc;
                fall_pend = 0;
            end
            prev_busy  = tx_busy[cur];
            prev_start = tx_start[cur];
        end
    end

    // Reference: the framed byte stream built straight from the frame format.
    function automatic void build_exp(input int n, input logic [95:0] d);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(n));
        x = 8'(n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(d[8*k +: 8]);
            x = x ^ d[8*k +: 8];
        end
        exp_q.push_back(x);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_data(input int u, input logic [95:0] d);
        if (u == 0) fdata0 = d[31:0];
        else fdata1 = d;
    endtask

    task automatic wait_ready(input int u);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (frame_ready[u]) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) fail_now("wait_ready");
    endtask

    task automatic offer(input int u, input logic [95:0] d);
        wait_ready(u);
        got_q.delete();
        done_cnt = 0;
        set_data(u, d);
        frame_valid[u] = 1'b1;
        @(posedge clk); #1;
        frame_valid[u] = 1'b0;
    endtask

    task automatic run_frame(input int u, input logic [95:0] d, input bit noisy, input int blen,
                             input logic [7:0] chk_exp, input bit use_chk);
        int total;
        bit ok;
        cur = u;
        busy_len = blen;
        never_ack[u] = 0;
        build_exp((u == 0) ? N0 : N1, d);
        total = exp_q.size();
        offer(u, d);
        check("fault_cleared_on_accept", 64'(fault[u]), 64'd0);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt != 0) begin
                ok = 1;
                break;
            end
            if (noisy && got_q.size() < total - 1 && $urandom_range(0, 3) == 0) begin
                frame_valid[u] = 1'b1;
                set_data(u, {$urandom(), $urandom(), $urandom()});
            end else begin
                frame_valid[u] = 1'b0;
            end
            @(posedge clk); #1;
        end
        frame_valid[u] = 1'b0;
        if (!ok) fail_now("frame_done_timeout");
        repeat (4) @(posedge clk);
        #1;
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("fault_after_frame", 64'(fault[u]), 64'd0);
        check("byte_count", 64'(got_q.size()), 64'(total));
        for (int k = 0; k < total && k < got_q.size(); k++)
            check("stream_byte", 64'(got_q[k]), 64'(exp_q[k]));
        if (use_chk && got_q.size() != 0)
            check("table_checksum", 64'(got_q[got_q.size()-1]), 64'(chk_exp));
        check("ready_after_frame", 64'(frame_ready[u]), 64'd1);
    endtask

    task automatic fault_test();
        cur = 0;
        busy_len = 4;
        never_ack[0] = 1;
        offer(0, 96'h44332211);
        @(negedge clk);
        check("fault_start_pulse", 64'(tx_start[0]), 64'd1);
        repeat (7) @(negedge clk);
        check("fault_early", 64'(fault[0]), 64'd0);
        check("fault_ready_early", 64'(frame_ready[0]), 64'd0);
        @(negedge clk);
        check("fault_set", 64'(fault[0]), 64'd1);
        check("fault_ready_set", 64'(frame_ready[0]), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("fault_sticky", 64'(fault[0]), 64'd1);
        check("fault_bytes", 64'(got_q.size()), 64'd1);
        if (got_q.size() != 0) check("fault_sof", 64'(got_q[0]), 64'hA5);
        check("fault_no_done", 64'(done_cnt), 64'd0);
        never_ack[0] = 0;
    endtask

    typedef struct {
        int         unit;
        logic [95:0] data;
        logic [7:0] chk;
        bit         noisy;
        int         blen;
    } vec_t;

    vec_t tbl[6];

    initial begin
        for (int u = 0; u < 2; u++) begin
            frame_valid[u] = 1'b0;
            abort[u]       = 1'b0;
            never_ack[u]   = 1'b0;
        end
        fdata0 = '0;
        fdata1 = '0;

        tbl[0] = '{0, 96'h44332211, 8'h40, 1'b0, 10};
        tbl[1] = '{0, 96'hDEADBEEF, 8'h26, 1'b1, 3};
        tbl[2] = '{0, 96'h00000000, 8'h04, 1'b0, 1};
        tbl[3] = '{0, 96'hFFFFFFFF, 8'h04, 1'b0, 2};
        tbl[4] = '{1, {96{1'b1}},   8'h0C, 1'b1, 4};
        tbl[5] = '{1, 96'h0,        8'h0C, 1'b0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_frame_ready", 64'(frame_ready[u]), 64'd1);
            check("rst_tx_start", 64'(tx_start[u]), 64'd0);
            check("rst_tx_data", 64'(tx_data[u]), 64'd0);
            check("rst_done", 64'(done[u]), 64'd0);
            check("rst_fault", 64'(fault[u]), 64'd0);
            check("rst_state_idle", 64'(state_dbg[u]), 64'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Table-driven frames
        for (int t = 0; t < 6; t++)
            run_frame(tbl[t].unit, tbl[t].data, tbl[t].noisy, tbl[t].blen, tbl[t].chk, 1'b1);

        // Ack timeout, then the next frame clears fault
        fault_test();
        run_frame(0, 96'h44332211, 1'b0, 10, 8'h40, 1'b1);

        // Abort during payload byte 0x22
        cur = 0;
        busy_len = 10;
        offer(0, 96'h44332211);
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 500; i++) begin
                if (got_q.size() >= 4) begin
                    ok = 1;
                    break;
                end
                @(posedge clk); #1;
            end
            if (!ok) fail_now("abort_reach_byte");
            if (got_q.size() >= 4) check("abort_target_byte", 64'(got_q[3]), 64'h22);
            abort[0] = 1'b1;
            @(posedge clk); #1;
            abort[0] = 1'b0;
            @(negedge clk);
            check("abort_state_idle", 64'(state_dbg[0]), 64'd0);
            check("abort_ready_low", 64'(frame_ready[0]), 64'd0);
            ok = 0;
            for (int i = 0; i < 100; i++) begin
                if (!tx_busy[0]) begin
                    ok = 1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) fail_now("abort_busy_fall");
            check("abort_ready_after_fall", 64'(frame_ready[0]), 64'd1);
            check("abort_no_done", 64'(done_cnt), 64'd0);
            check("abort_bytes", 64'(got_q.size()), 64'd4);
        end
        @(posedge clk); #1;
        run_frame(0, 96'hDEADBEEF, 1'b0, 5, 8'h26, 1'b1);

        // Reset mid-frame on the 12-byte unit while the 4-byte unit holds a fault
        fault_test();
        cur = 1;
        busy_len = 5;
        offer(1, {$urandom(), $urandom(), $urandom()});
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 500; i++) begin
                if (got_q.size() >= 3) begin
                    ok = 1;
                    break;
                end
                @(posedge clk); #1;
            end
            if (!ok) fail_now("reset_reach_byte");
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_tx_start", 64'(tx_start[1]), 64'd0);
        check("midrst_done", 64'(done[1]), 64'd0);
        check("midrst_ready", 64'(frame_ready[1]), 64'd1);
        check("midrst_tx_data", 64'(tx_data[1]), 64'd0);
        check("midrst_fault_other", 64'(fault[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(1, {$urandom(), $urandom(), $urandom()}, 1'b0, 3, 8'h00, 1'b0);

        // Randomized frames against the stream model
        for (int r = 0; r < 16; r++)
            run_frame(r % 2, {$urandom(), $urandom(), $urandom()}, $urandom_range(0, 1) == 1,
                      $urandom_range(1, 12), 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got time limit, want completion");
        $fatal(1, "watchdog");
    end
endmodule
